mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage RV32I pipeline, between the EX/MEM register and the writeback stage. Issues load/store requests to the data-memory port with a request/response handshake, forms byte enables and lane-shifted store data, and stalls the pipeline while an access is outstanding. Owns the MEM/WB pipeline register, which supplies loaded data, control and address bits to writeback for load extension and regfile-mux selection.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  EX/MEM holds a real instruction (0 = bubble).
- in_mem_read / in_mem_write  in  1 each  instruction is a load / store; never both.
- in_funct3  in  3  load/store width code (lb/lh/lw/lbu/lhu, sb/sh/sw).
- in_alu_out  in  32  effective address, or ALU result for non-memory ops.
- in_rs2_out  in  32  store source data.
- in_br_en, in_u_imm[31:0], in_pc[31:0], in_regfilemux_sel, in_load_regfile, in_rd[4:0]  in  —  forwarded to MEM/WB.
- stall_in  in  1  freeze request from other stages (e.g. instruction-fetch miss).
- data_mem_address  out  32  {in_alu_out[31:2], 2'b00}.
- data_mem_read / data_mem_write  out  1 each  request strobes, held until response.
- data_mem_mbe  out  4  byte enables for writes.
- data_mem_wdata  out  32  lane-aligned store data.
- data_mem_rdata  in  32  read data, valid when data_mem_resp = 1.
- data_mem_resp  in  1  one-cycle completion pulse.
- stall_mem  out  1  freeze EX/MEM and earlier stages.
- wb_valid, wb_data_value[31:0], wb_funct3[2:0], wb_br_en, wb_alu_out[31:0], wb_u_imm[31:0], wb_pc[31:0], wb_addr_lo2[1:0], wb_regfilemux_sel, wb_load_regfile, wb_rd[4:0]  out  —  MEM/WB register contents.

## Operation
- mem_op = in_valid & (in_mem_read | in_mem_write).
- States:
  - IDLE: no access outstanding.
  - BUSY: request outstanding, no response yet.
  - HOLD: response captured; pipeline frozen by stall_in.
- Request strobes: data_mem_read = in_mem_read & in_valid & (IDLE | BUSY), likewise data_mem_write. Both are 0 in HOLD and while rst = 1.
- Transitions:
  - IDLE, mem_op & ~resp -> BUSY.
  - IDLE or BUSY, resp & stall_in -> HOLD; data_mem_rdata latched into the hold buffer.
  - IDLE or BUSY, resp & ~stall_in -> IDLE.
  - HOLD, ~stall_in -> IDLE.
  - Otherwise the state is unchanged.
- stall_mem = mem_op & ~data_mem_resp in IDLE/BUSY; 0 in HOLD; 0 when ~mem_op.
- advance = ~stall_in & ~stall_mem.
- MEM/WB register update:
  - advance: loads all in_* fields. wb_valid = in_valid; wb_addr_lo2 = in_alu_out[1:0].
  - wb_data_value takes data_mem_rdata on a same-cycle response, the hold buffer in HOLD, otherwise 0.
  - stall_mem & ~stall_in: wb_valid = 0 and wb_load_regfile = 0 (bubble); other fields hold.
  - stall_in: all fields hold.
- Store byte enables (a = in_alu_out[1:0]):
  - sw: mbe = 1111, wdata = rs2.
  - sh: mbe = 0011 << (2·a[1]), wdata = rs2 << (16·a[1]); a[0] ignored.
  - sb: mbe = 0001 << a, wdata = rs2 << (8·a).
  - mbe = 0000 when not writing.
- Misaligned accesses are not trapped; the low address bits are dropped as above.

## Timing
- Reset values: state IDLE, hold buffer 0, all wb_* 0 (wb_regfilemux_sel = alu_out encoding), stall_mem 0, request strobes 0.
- Non-memory instruction: zero stall; it appears on wb_* the cycle after it is presented.
- Load/store with response N cycles after first assertion (N ≥ 0; N = 0 means resp in the issue cycle):
  - stall_mem is high for N cycles.
  - The request is held stable for N+1 cycles.
  - wb_* update on the edge ending the response cycle.
- Simultaneous resp and stall_in: no re-issue. Strobes drop the next cycle (HOLD); data is preserved until release.
- rst asserted mid-BUSY: strobes drop immediately (combinationally) and the state returns to IDLE. Any late response after reset is ignored unless a new mem_op is present.

## Test plan
- ALU op, in_alu_out = 0x1234, no stalls -> wb_alu_out = 0x1234 next cycle, data_mem_read and data_mem_write never asserted.
- lw at 0x100, resp 2 cycles after issue with rdata 0xDEADBEEF:
  - data_mem_read is high for 3 cycles and stall_mem for 2.
  - wb_valid = 0 during the stall.
  - wb_data_value = 0xDEADBEEF with wb_addr_lo2 = 00.
- sb at 0x203, rs2 = 0x000000AB -> address 0x200, mbe = 1000, wdata = 0xAB000000. sh at 0x202 -> mbe = 1100, wdata = rs2 << 16.
- lw, resp in the issue cycle while stall_in = 1 for 3 cycles:
  - The state reaches HOLD and strobes drop after one cycle.
  - stall_mem = 0 throughout.
  - wb_data_value receives the latched rdata when stall_in falls.
- rst pulsed while BUSY -> strobes fall in the same cycle, all wb_* = 0, and after release a back-to-back new store issues normally.
- Two consecutive loads each with 1-cycle latency -> each shows one stall cycle, and wb_data_value sequences correctly with no dropped or duplicated instruction.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory port between the MEM stage and the data cache/memory.
// Request strobes are held until the one-cycle resp pulse.
interface mem_stage_if;
    logic [31:0] data_mem_address;
    logic        data_mem_read;
    logic        data_mem_write;
    logic [3:0]  data_mem_mbe;
    logic [31:0] data_mem_wdata;
    logic [31:0] data_mem_rdata;
    logic        data_mem_resp;

    modport master (
        output data_mem_address, data_mem_read, data_mem_write,
               data_mem_mbe, data_mem_wdata,
        input  data_mem_rdata, data_mem_resp
    );

    modport slave (
        input  data_mem_address, data_mem_read, data_mem_write,
               data_mem_mbe, data_mem_wdata,
        output data_mem_rdata, data_mem_resp
    );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues loads/stores on the data-memory port,
// stalls the pipeline while an access is outstanding, and owns the MEM/WB
// register. A response that arrives while the pipeline is frozen is parked
// in a hold buffer so the access is never re-issued.
module mem_stage (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_alu_out,
    input  logic [31:0]       in_rs2_out,
    input  logic              in_br_en,
    input  logic [31:0]       in_u_imm,
    input  logic [31:0]       in_pc,
    input  logic [3:0]        in_regfilemux_sel,
    input  logic              in_load_regfile,
    input  logic [4:0]        in_rd,
    input  logic              stall_in,
    mem_stage_if.master       dmem,
    output logic              stall_mem,
    output logic              wb_valid,
    output logic [31:0]       wb_data_value,
    output logic [2:0]        wb_funct3,
    output logic              wb_br_en,
    output logic [31:0]       wb_alu_out,
    output logic [31:0]       wb_u_imm,
    output logic [31:0]       wb_pc,
    output logic [1:0]        wb_addr_lo2,
    output logic [3:0]        wb_regfilemux_sel,
    output logic              wb_load_regfile,
    output logic [4:0]        wb_rd
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] hold_buf;
    logic        mem_op;
    logic        active;
    logic        resp_ok;
    logic        advance;

    // Byte enables for a store; a[0] is ignored for halfwords (no misalign trap).
    function automatic logic [3:0] store_mbe(input logic [2:0] funct3, input logic [1:0] a);
        case (funct3)
            3'b000:  store_mbe = 4'b0001 << a;
            3'b001:  store_mbe = 4'b0011 << {a[1], 1'b0};
            default: store_mbe = 4'b1111;
        endcase
    endfunction

    // Store data shifted onto the byte lanes selected by the address.
    function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [1:0] a,
                                                input logic [31:0] rs2);
        case (funct3)
            3'b000:  store_wdata = rs2 << {a, 3'b000};
            3'b001:  store_wdata = rs2 << {a[1], 4'b0000};
            default: store_wdata = rs2;
        endcase
    endfunction

    assign mem_op  = in_valid & (in_mem_read | in_mem_write);
    assign active  = (state != HOLD);
    // A stray response with no memory op in flight (e.g. after reset) is ignored.
    assign resp_ok = dmem.data_mem_resp & mem_op & active;

    assign stall_mem = mem_op & ~dmem.data_mem_resp & active;
    assign advance   = ~stall_in & ~stall_mem;

    assign dmem.data_mem_address = {in_alu_out[31:2], 2'b00};
    assign dmem.data_mem_read    = in_valid & in_mem_read  & active & ~rst;
    assign dmem.data_mem_write   = in_valid & in_mem_write & active & ~rst;
    assign dmem.data_mem_mbe     = dmem.data_mem_write ? store_mbe(in_funct3, in_alu_out[1:0]) : 4'b0000;
    assign dmem.data_mem_wdata   = store_wdata(in_funct3, in_alu_out[1:0], in_rs2_out);

    // Next-state: wait for resp, park it in HOLD if the pipeline is frozen.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, BUSY: begin
                if (resp_ok)
                    state_next = stall_in ? HOLD : IDLE;
                else if (mem_op)
                    state_next = BUSY;
            end
            HOLD: begin
                if (!stall_in)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Access-tracking state and the hold buffer for responses captured under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_buf <= 32'd0;
        end else begin
            state <= state_next;
            if (resp_ok && stall_in)
                hold_buf <= dmem.data_mem_rdata;
        end
    end

    // MEM/WB register: load on advance, insert a bubble on a memory stall, hold on stall_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid          <= 1'b0;
            wb_data_value     <= 32'd0;
            wb_funct3         <= 3'd0;
            wb_br_en          <= 1'b0;
            wb_alu_out        <= 32'd0;
            wb_u_imm          <= 32'd0;
            wb_pc             <= 32'd0;
            wb_addr_lo2       <= 2'd0;
            wb_regfilemux_sel <= 4'd0;
            wb_load_regfile   <= 1'b0;
            wb_rd             <= 5'd0;
        end else if (advance) begin
            wb_valid          <= in_valid;
            wb_data_value     <= resp_ok ? dmem.data_mem_rdata :
                                 (state == HOLD) ? hold_buf : 32'd0;
            wb_funct3         <= in_funct3;
            wb_br_en          <= in_br_en;
            wb_alu_out        <= in_alu_out;
            wb_u_imm          <= in_u_imm;
            wb_pc             <= in_pc;
            wb_addr_lo2       <= in_alu_out[1:0];
            wb_regfilemux_sel <= in_regfilemux_sel;
            wb_load_regfile   <= in_load_regfile;
            wb_rd             <= in_rd;
        end else if (!stall_in) begin
            wb_valid        <= 1'b0;
            wb_load_regfile <= 1'b0;
        end
    end

endmodule
